// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. buffered coprocessor completions.
// Optional long-latency destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      wb_op,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [XLEN-1:0] wb_mem,
  input  logic [XLEN-1:0] wb_imm,
  input  logic [XLEN-1:0] wb_pc4,
  output logic            pipe_stall,
  input  logic            co_valid,
  output logic            co_ready,
  input  logic [4:0]      co_rd,
  input  logic [XLEN-1:0] co_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            hazard,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic [SW-1:0]   r_starve;
  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  logic            w_en, w_empty, w_full, w_preq, w_push, w_pop;
  logic [1:0]      w_sel;
  logic [4:0]      w_rd, w_head_rd;
  logic [XLEN-1:0] w_head_data, w_pipe_data;

  assign w_en  = wb_op[0];
  assign w_sel = wb_op[2:1];
  assign w_rd  = wb_op[7:3];

  // Completion handshake: an entry transfers on a rising edge where co_valid && co_ready;
  // co_ready depends only on FIFO occupancy, never on co_valid.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign co_ready = !w_full;
  assign w_push   = co_valid && !w_full;

  assign pipe_stall  = !w_empty && (r_starve == STARVE_MAX);
  assign w_preq      = w_en && (w_rd != 5'd0) && !pipe_stall;
  assign w_pop       = !w_empty && !w_preq;
  assign w_head_rd   = r_fifo_rd[r_rptr[AW-1:0]];
  assign w_head_data = r_fifo_data[r_rptr[AW-1:0]];

  always_comb begin
    w_pipe_data = wb_alu;
    case (w_sel)
      2'b00: w_pipe_data = wb_alu;
      2'b01: w_pipe_data = wb_mem;
      2'b10: w_pipe_data = wb_imm;
      2'b11: w_pipe_data = wb_pc4;
      default: w_pipe_data = wb_alu;
    endcase
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr[AW-1:0]]   <= co_rd;
      r_fifo_data[r_wptr[AW-1:0]] <= co_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_pop)                   r_starve <= '0;
      else if (!w_empty && w_preq) r_starve <= r_starve + STARVE_ONE;
    end
  end

  // Address/data hold when nothing is written, including popped rd=0 completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_preq) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_rd;
      r_rf_wdata <= w_pipe_data;
    end else if (w_pop && (w_head_rd != 5'd0)) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head_rd;
      r_rf_wdata <= w_head_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_pend;
  logic [31:0] w_pend_set, w_pend_clr;

  // Release happens one edge after the write is presented, so the regfile already holds the value.
  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    if (iss_valid && (iss_rd != 5'd0)) w_pend_set[iss_rd] = 1'b1;
    if (r_rf_we) w_pend_clr[r_rf_waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
  end

  assign hazard = r_pend[chk_rs1] | r_pend[chk_rs2] | r_pend[chk_rd];
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd};
  assign hazard      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int XLEN = 32, FIFO_DEPTH = 4, STARVE_LIMIT = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]      wb_op;
  logic [XLEN-1:0] wb_alu, wb_mem, wb_imm, wb_pc4, co_data, rf_wdata;
  logic            pipe_stall, co_valid, co_ready, iss_valid, hazard, rf_we;
  logic [4:0]      co_rd, iss_rd, chk_rs1, chk_rs2, chk_rd, rf_waddr;

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .wb_op(wb_op), .wb_alu(wb_alu), .wb_mem(wb_mem),
    .wb_imm(wb_imm), .wb_pc4(wb_pc4), .pipe_stall(pipe_stall), .co_valid(co_valid),
    .co_ready(co_ready), .co_rd(co_rd), .co_data(co_data), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // scoreboard / reference model
  int n_total = 0, n_bad = 0;
  logic [XLEN+4:0] exp_q[$];
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [31:0]     m_pend;
  int              m_starve;
  logic            last_stall, last_haz, last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_hazard();
`ifdef WB_SCOREBOARD_EN
    return m_pend[chk_rs1] | m_pend[chk_rs2] | m_pend[chk_rd];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_pend = '0; m_starve = 0;
  endtask

  // driver tasks
  task automatic idle_inputs();
    wb_op = '0; wb_alu = '0; wb_mem = '0; wb_imm = '0; wb_pc4 = '0;
    co_valid = 1'b0; co_rd = '0; co_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  task automatic set_pipe(input logic en, input logic [4:0] rd, input logic [1:0] sel);
    wb_op  = {rd, sel, en};
    wb_alu = $urandom; wb_mem = $urandom; wb_imm = $urandom; wb_pc4 = $urandom;
  endtask

  task automatic set_co(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    co_valid = v; co_rd = rd; co_data = d;
  endtask

  // One clock cycle: entered at a falling edge with inputs applied, returns at the next falling edge.
  task automatic step();
    logic exp_stall, exp_ready, preq, pop, push;
    logic [XLEN+4:0] head;
    logic [XLEN-1:0] src [4];
    #1;
    exp_stall = (exp_q.size() > 0) && (m_starve == STARVE_LIMIT - 1);
    exp_ready = (exp_q.size() < FIFO_DEPTH);
    last_stall = pipe_stall; last_haz = hazard; last_ready = co_ready;
    check("pipe_stall", pipe_stall, exp_stall);
    check("co_ready", co_ready, exp_ready);
    check("hazard", hazard, exp_hazard());
    src  = '{wb_alu, wb_mem, wb_imm, wb_pc4};
    preq = wb_op[0] && (wb_op[7:3] != 5'd0) && !exp_stall;
    pop  = (exp_q.size() > 0) && !preq;
    push = co_valid && exp_ready;
    if (m_we) m_pend[m_addr] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
    m_pend[0] = 1'b0;
    if (pop) m_starve = 0;
    else if (exp_q.size() > 0 && preq) m_starve++;
    if (preq) begin
      m_we = 1'b1; m_addr = wb_op[7:3]; m_data = src[wb_op[2:1]];
    end else if (pop) begin
      head = exp_q.pop_front();
      m_we = (head[XLEN+4:XLEN] != 5'd0);
      if (m_we) begin m_addr = head[XLEN+4:XLEN]; m_data = head[XLEN-1:0]; end
    end else begin
      m_we = 1'b0;
    end
    if (push) exp_q.push_back({co_rd, co_data});
    @(posedge clk); #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_addr);
    check("rf_wdata", rf_wdata, m_data);
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check("rst_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, 5'd0);
    check("rst_wdata", rf_wdata, '0);
    check("rst_ready", co_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first, stalls;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_we", rf_we, 1'b0);
    check("reset_waddr", rf_waddr, 5'd0);
    check("reset_wdata", rf_wdata, '0);
    check("reset_ready", co_ready, 1'b1);
    check("reset_stall", pipe_stall, 1'b0);
    check("reset_hazard", hazard, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // pipeline writeback, latency 1
    set_pipe(1'b1, 5'd5, 2'b00); wb_alu = 32'h1234; step();
    check("t1_we", rf_we, 1'b1); check("t1_addr", rf_waddr, 5'd5); check("t1_data", rf_wdata, 32'h1234);
    set_pipe(1'b1, 5'd1, 2'b11); wb_pc4 = 32'h80; step();
    check("t2_data", rf_wdata, 32'h80);
    set_pipe(1'b1, 5'd0, 2'b11); step();
    check("t2_rd0_we", rf_we, 1'b0);

    // completion through an idle pipe
    set_pipe(1'b0, 5'd0, 2'b00); set_co(1'b1, 5'd7, 32'hAA); step();
    set_co(1'b0, 5'd0, '0); step();
    check("t3_we", rf_we, 1'b1); check("t3_addr", rf_waddr, 5'd7); check("t3_data", rf_wdata, 32'hAA);

    // starvation: one queued entry behind a busy pipe
    set_pipe(1'b1, 5'd3, 2'b00); set_co(1'b1, 5'd4, 32'h55); step();
    set_co(1'b0, 5'd0, '0);
    first = 0; stalls = 0;
    for (int k = 1; k <= 12; k++) begin
      set_pipe(1'b1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3))); step();
      if (last_stall) begin stalls++; if (first == 0) first = k; end
    end
    check("t4_stall_at", first, 8);
    check("t4_stall_cnt", stalls, 1);

    // fill the FIFO while the pipe keeps the port busy
    for (int i = 0; i < 4; i++) begin
      set_pipe(1'b1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)));
      set_co(1'b1, 5'(i + 1), $urandom); step();
    end
    #1 check("t5_full", co_ready, 1'b0);
    set_co(1'b1, 5'd20, 32'h5555);
    first = 0;
    for (int k = 1; k <= 12 && first == 0; k++) begin
      set_pipe(1'b1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3))); step();
      if (last_ready) first = k;
    end
    check("t5_accept_at", first, 6);
    set_co(1'b0, 5'd0, '0); set_pipe(1'b0, 5'd0, 2'b00);
    repeat (6) step();

`ifdef WB_SCOREBOARD_EN
    iss_valid = 1'b1; iss_rd = 5'd9; step();
    iss_valid = 1'b0; chk_rs1 = 5'd9; step();
    check("t6_haz_set", last_haz, 1'b1);
    set_co(1'b1, 5'd9, 32'h99); step();
    set_co(1'b0, 5'd0, '0); step();
    check("t6_we", rf_we, 1'b1); check("t6_addr", rf_waddr, 5'd9);
    step(); check("t6_haz_hold", last_haz, 1'b1);
    step(); check("t6_haz_clr", last_haz, 1'b0);
    chk_rs1 = '0;
`endif

    // reset with queued entries and a pending destination
    for (int i = 0; i < 3; i++) begin
      set_pipe(1'b1, 5'($urandom_range(1, 31)), 2'b00);
      set_co(1'b1, 5'(i + 10), $urandom);
      iss_valid = 1'b1; iss_rd = 5'd12; step();
    end
    idle_inputs();
    reset_mid();
    chk_rs1 = 5'd12;
    repeat (3) step();
    chk_rs1 = '0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_pipe($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      set_co($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom);
      iss_valid = ($urandom_range(0, 9) < 2); iss_rd = 5'($urandom_range(0, 15));
      chk_rs1 = 5'($urandom_range(0, 15)); chk_rs2 = 5'($urandom_range(0, 15));
      chk_rd = 5'($urandom_range(0, 15));
      step();
      if (i == 300) reset_mid();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
